// File: rtl/switch_pkg.sv
// Shared constants for the switch conditioning path: board clock, debounce
// window and the counter-width helper used by each channel.
package switch_pkg;

    localparam int CLK_HZ                 = 12_000_000;
    localparam int DEBOUNCE_MS            = 10;
    localparam int DEBOUNCE_LIMIT_DEFAULT = CLK_HZ / 1000 * DEBOUNCE_MS;

    // Counter only has to reach limit-1, so clog2(limit) bits suffice.
    function automatic int cnt_width(input int limit);
        return (limit <= 2) ? 1 : $clog2(limit);
    endfunction

endpackage

// File: rtl/switch_debounce_ch.sv
// One switch channel: input synchroniser, stability counter, debounced level,
// registered press/release pulses and press-driven toggle.
module switch_debounce_ch
    import switch_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT,
    parameter int SYNC_STAGES    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic db,
    output logic press,
    output logic rel,
    output logic toggle
);

    localparam int            CW      = cnt_width(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_LIMIT - 1);

    logic [SYNC_STAGES-1:0] sync_pipe;
    logic [CW-1:0]          cnt;
    logic                   sync;
    logic                   mismatch;
    logic                   hit;

    always_comb begin
        sync     = sync_pipe[SYNC_STAGES-1];
        mismatch = (sync != db);
        hit      = mismatch && (cnt == CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_pipe <= '0;
            cnt       <= '0;
            db        <= 1'b0;
            press     <= 1'b0;
            rel       <= 1'b0;
            toggle    <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], sw};
            // Pulses are registered alongside db so they line up with the new level.
            press     <= hit && sync;
            rel       <= hit && !sync;
            if (hit && sync)
                toggle <= ~toggle;
            if (!mismatch) begin
                cnt <= '0;
            end else if (hit) begin
                cnt <= '0;
                db  <= sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assert property (@(posedge clk) disable iff (rst) cnt <= CNT_MAX);

endmodule

// File: rtl/switch_debounce_bank.sv
// Bank of NUM_SW independent debounce channels feeding the switch-to-LED logic.
module switch_debounce_bank
    import switch_pkg::*;
#(
    parameter int NUM_SW         = 4,
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT,
    parameter int SYNC_STAGES    = 2
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic [NUM_SW-1:0] i_Switch,
    output logic [NUM_SW-1:0] o_Switch_Db,
    output logic [NUM_SW-1:0] o_Press,
    output logic [NUM_SW-1:0] o_Release,
    output logic [NUM_SW-1:0] o_Toggle
);

    for (genvar g = 0; g < NUM_SW; g++) begin : g_ch
        switch_debounce_ch #(
            .DEBOUNCE_LIMIT(DEBOUNCE_LIMIT),
            .SYNC_STAGES   (SYNC_STAGES)
        ) u_ch (
            .clk    (i_Clk),
            .rst    (i_Rst),
            .sw     (i_Switch[g]),
            .db     (o_Switch_Db[g]),
            .press  (o_Press[g]),
            .rel    (o_Release[g]),
            .toggle (o_Toggle[g])
        );
    end

endmodule

// File: tb/tb_switch_debounce_bank.sv
// Scoreboard bench: stimulus queues expected output events with their cycle,
// a negedge monitor pops one entry for every change it sees on the outputs.
module tb_switch_debounce_bank;

    localparam int NUM_SW = 4;
    localparam int LIMIT  = 8;
    localparam int SYNC   = 2;
    localparam int LAT    = SYNC + LIMIT;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NUM_SW-1:0] sw  = '0;
    logic [NUM_SW-1:0] db, press, rel, tog;

    typedef struct {
        int          cyc;
        logic [15:0] val;
        string       name;
    } ev_t;

    ev_t        exp_q[$];
    int         cyc    = 0;
    int         errors = 0;
    int         checks = 0;
    logic [3:0] m_db   = '0;
    logic [3:0] m_tog  = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    switch_debounce_bank #(
        .NUM_SW        (NUM_SW),
        .DEBOUNCE_LIMIT(LIMIT),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Switch   (sw),
        .o_Switch_Db(db),
        .o_Press    (press),
        .o_Release  (rel),
        .o_Toggle   (tog)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Drive the pins just after an edge; the level lands LAT edges later and the pulse drops one edge after that.
    task automatic drive(input logic [3:0] mask, input logic lvl, input string name);
        ev_t        e;
        logic [3:0] p, r;
        sw = lvl ? (sw | mask) : (sw & ~mask);
        p  = lvl ? mask : 4'b0;
        r  = lvl ? 4'b0 : mask;
        if (lvl) begin
            m_db  = m_db | mask;
            m_tog = m_tog ^ mask;
        end else begin
            m_db = m_db & ~mask;
        end
        e.cyc = cyc + LAT;     e.val = {m_db, p, r, m_tog};       e.name = name;
        exp_q.push_back(e);
        e.cyc = cyc + LAT + 1; e.val = {m_db, 4'b0, 4'b0, m_tog}; e.name = {name, "_end"};
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        logic [15:0] prev, cur;
        ev_t         e;
        prev = '0;
        forever begin
            @(negedge clk);
            cur = {db, press, rel, tog};
            if (rst) begin
                prev = cur;
            end else if (cur != prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: cyc %0d got %h expected no change", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || cur !== e.val) begin
                        errors++;
                        $display("FAIL %s: got %h at cyc %0d expected %h at cyc %0d",
                                 e.name, cur, cyc, e.val, e.cyc);
                    end
                end
                prev = cur;
            end
        end
    end

    initial begin : stim
        #12;
        check("reset_state", {db, press, rel, tog}, 16'h0);
        step(1);
        rst = 1'b0;
        step(3);

        // Clean press, release and second press on switch 1.
        drive(4'b0001, 1'b1, "s1_press");     step(20);
        drive(4'b0001, 1'b0, "s3_release");   step(20);
        drive(4'b0001, 1'b1, "s3_press2");    step(20);
        drive(4'b0001, 1'b0, "s3_release2");  step(20);

        // All four switches on the same edge.
        drive(4'b1111, 1'b1, "s4_press_all");   step(20);
        drive(4'b1111, 1'b0, "s4_release_all"); step(20);

        // Bounce on switch 2: neither high burst reaches the full window.
        sw[1] = 1'b1; step(5);
        sw[1] = 1'b0; step(2);
        sw[1] = 1'b1; step(7);
        sw[1] = 1'b0; step(15);
        drive(4'b0010, 1'b1, "s2_press");   step(20);
        drive(4'b0010, 1'b0, "s2_release"); step(20);

        // Reset while switch 3 is five counts into its window.
        sw[2] = 1'b1;
        step(7);
        #2 rst = 1'b1;
        #1 check("reset_async", {db, press, rel, tog}, 16'h0);
        m_db  = '0;
        m_tog = '0;
        step(2);
        rst = 1'b0;
        drive(4'b0100, 1'b1, "s5_press");   step(20);
        drive(4'b0100, 1'b0, "s5_release"); step(20);

        // Switch 4 chattering with a 7-cycle half period never settles.
        repeat (28) begin
            sw[3] = ~sw[3];
            step(7);
        end
        step(15);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d still queued, next %s at cyc %0d",
                     exp_q.size(), exp_q[0].name, exp_q[0].cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
